// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of a single data-memory/LSU port. Port 0 has fixed
// priority; a starvation counter forces port 1 through, and a timeout returns an error.
module lsu_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,

    input  logic                i_p0_req,
    input  logic                i_p0_wren,
    input  logic [ADDR_W-1:0]   i_p0_addr,
    input  logic [DATA_W-1:0]   i_p0_wdata,
    input  logic [DATA_W/8-1:0] i_p0_strb,
    output logic                o_p0_gnt,
    output logic                o_p0_rvld,
    output logic [DATA_W-1:0]   o_p0_rdata,
    output logic                o_p0_err,

    input  logic                i_p1_req,
    input  logic                i_p1_wren,
    input  logic [ADDR_W-1:0]   i_p1_addr,
    input  logic [DATA_W-1:0]   i_p1_wdata,
    input  logic [DATA_W/8-1:0] i_p1_strb,
    output logic                o_p1_gnt,
    output logic                o_p1_rvld,
    output logic [DATA_W-1:0]   o_p1_rdata,
    output logic                o_p1_err,

    output logic                o_mem_req,
    output logic                o_mem_wren,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_strb,
    input  logic                i_mem_rvld,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic                o_busy
);

    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(MAX_STARVE);
    localparam logic [7:0]  TMO_LIMIT  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [3:0]          starve_cnt;
    logic [7:0]          tmo_cnt;
    logic                owner;
    logic                cap_wren;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [STRB_W-1:0]   cap_strb;

    logic                p0_win;
    logic                p1_win;
    logic                grant;
    logic                tmo_hit;
    logic                rsp_fire;

    // Port 1 wins when alone, or when port 0 has used up its contended-grant budget.
    always_comb begin
        p1_win   = i_p1_req && (!i_p0_req || (starve_cnt == STARVE_MAX));
        p0_win   = i_p0_req && !p1_win;
        grant    = (state == ST_IDLE) && (p0_win || p1_win);
        tmo_hit  = (tmo_cnt + 8'd1) == TMO_LIMIT;
        rsp_fire = (state == ST_WAIT) && (i_mem_rvld || tmo_hit);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The memory acknowledge is only sampled in WAIT, so an ack during CMD is ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (i_p0_req || i_p1_req) state_nxt = ST_CMD;
            ST_CMD:  state_nxt = ST_WAIT;
            ST_WAIT: if (rsp_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        o_p0_gnt   = i_rst_n && (state == ST_IDLE) && p0_win;
        o_p1_gnt   = i_rst_n && (state == ST_IDLE) && p1_win;
        o_mem_req  = (state == ST_CMD);
        o_mem_wren = (state == ST_CMD) && cap_wren;
        o_mem_strb = (state == ST_CMD) ? cap_strb : '0;
        o_mem_addr = cap_addr;
        o_mem_wdata = cap_wdata;
        o_busy     = (state != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner     <= 1'b0;
            cap_wren  <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
        end else if (grant) begin
            owner     <= p1_win;
            cap_wren  <= p1_win ? i_p1_wren  : i_p0_wren;
            cap_addr  <= p1_win ? i_p1_addr  : i_p0_addr;
            cap_wdata <= p1_win ? i_p1_wdata : i_p0_wdata;
            cap_strb  <= p1_win ? i_p1_strb  : i_p0_strb;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (p1_win) begin
                starve_cnt <= '0;
            end else if (i_p1_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_CMD) begin
            tmo_cnt <= '0;
        end else if ((state == ST_WAIT) && !rsp_fire) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // An ack on the timeout edge wins over the error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_p0_rvld  <= 1'b0;
            o_p0_err   <= 1'b0;
            o_p0_rdata <= '0;
            o_p1_rvld  <= 1'b0;
            o_p1_err   <= 1'b0;
            o_p1_rdata <= '0;
        end else begin
            o_p0_rvld <= 1'b0;
            o_p0_err  <= 1'b0;
            o_p1_rvld <= 1'b0;
            o_p1_err  <= 1'b0;
            if (rsp_fire) begin
                if (owner) begin
                    o_p1_rvld  <= 1'b1;
                    o_p1_err   <= !i_mem_rvld;
                    o_p1_rdata <= i_mem_rvld ? i_mem_rdata : '0;
                end else begin
                    o_p0_rvld  <= 1'b1;
                    o_p0_err   <= !i_mem_rvld;
                    o_p0_rdata <= i_mem_rvld ? i_mem_rdata : '0;
                end
            end
        end
    end

endmodule
